// File: rtl/dataplane_axil_regs.sv
// rtl/dataplane_axil_regs.sv - AXI4-Lite responder for the dataplane control/status register file
// Optional feature macro: DATAPLANE_AXIL_SLVERR_EN (SLVERR + 0xDEADBEEF on unmapped accesses)
module dataplane_axil_regs #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'hD47A_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           ctrl_o,
  input  logic [31:0]           status_i
);

  localparam int WA = ADDR_WIDTH - 2;
  localparam logic [WA-1:0] A_ID      = WA'(0);
  localparam logic [WA-1:0] A_CTRL    = WA'(1);
  localparam logic [WA-1:0] A_STATUS  = WA'(2);
  localparam logic [WA-1:0] A_WCOUNT  = WA'(3);
  localparam logic [WA-1:0] A_SCRATCH = {WA{1'b1}};
  localparam logic [1:0]    RESP_OKAY = 2'b00;

`ifdef DATAPLANE_AXIL_SLVERR_EN
  localparam logic [1:0]  UNMAPPED_RESP  = 2'b10;
  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;
`else
  localparam logic [1:0]  UNMAPPED_RESP  = 2'b00;
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t       w_state_q, w_state_d;
  r_state_t       r_state_q, r_state_d;
  logic           aw_have_q, aw_have_d;
  logic           w_have_q, w_have_d;
  logic [WA-1:0]  awaddr_q, awaddr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic           awready_q, awready_d;
  logic           wready_q, wready_d;
  logic [1:0]     bresp_q, bresp_d;
  logic [31:0]    ctrl_q, ctrl_d;
  logic [31:0]    scratch_q, scratch_d;
  logic [31:0]    wcount_q, wcount_d;
  logic           arready_q, arready_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;

  logic          aw_hs, w_hs, ar_hs;
  logic [WA-1:0] ar_word;
  logic          unused_addr_lsbs;

  assign aw_hs   = s_axi_awvalid && awready_q;
  assign w_hs    = s_axi_wvalid && wready_q;
  assign ar_hs   = s_axi_arvalid && arready_q;
  assign ar_word = s_axi_araddr[ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Write channel: AW and W are captured independently; commit happens one edge after both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    wcount_d  = wcount_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_have_q && w_have_q) begin
          w_state_d = W_RESP;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (awaddr_q == A_CTRL) begin
            ctrl_d   = merge_bytes(ctrl_q, wdata_q, wstrb_q);
            wcount_d = wcount_q + 32'd1;
            bresp_d  = RESP_OKAY;
          end else if (awaddr_q == A_SCRATCH) begin
            scratch_d = merge_bytes(scratch_q, wdata_q, wstrb_q);
            wcount_d  = wcount_q + 32'd1;
            bresp_d   = RESP_OKAY;
          end else if (awaddr_q == A_ID || awaddr_q == A_STATUS || awaddr_q == A_WCOUNT) begin
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = UNMAPPED_RESP;
          end
        end else begin
          if (aw_hs) begin
            aw_have_d = 1'b1;
            awaddr_d  = s_axi_awaddr[ADDR_WIDTH-1:2];
            awready_d = 1'b0;
          end else if (!aw_have_q) begin
            awready_d = 1'b1;
          end
          if (w_hs) begin
            w_have_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
            wready_d = 1'b0;
          end else if (!w_have_q) begin
            wready_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: data is sampled from the current (pre-commit) register values at the AR handshake.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rresp_d   = RESP_OKAY;
          if (ar_word == A_ID)           rdata_d = ID_VALUE;
          else if (ar_word == A_CTRL)    rdata_d = ctrl_q;
          else if (ar_word == A_STATUS)  rdata_d = status_i;
          else if (ar_word == A_WCOUNT)  rdata_d = wcount_q;
          else if (ar_word == A_SCRATCH) rdata_d = scratch_q;
          else begin
            rdata_d = UNMAPPED_RDATA;
            rresp_d = UNMAPPED_RESP;
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= 2'b00;
      ctrl_q    <= '0;
      scratch_q <= '0;
      wcount_q  <= '0;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bresp_q   <= bresp_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      wcount_q  <= wcount_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ctrl_o        = ctrl_q;

endmodule

// File: tb/tb_dataplane_axil_regs.sv
// tb/tb_dataplane_axil_regs.sv - directed self-checking bench for dataplane_axil_regs
// Expected unmapped responses follow DATAPLANE_AXIL_SLVERR_EN when defined.
module tb_dataplane_axil_regs;

  localparam logic [31:0] ID_VALUE = 32'hD47A_0001;
`ifdef DATAPLANE_AXIL_SLVERR_EN
  localparam logic [31:0] EXP_UNM_RESP  = 32'd2;
  localparam logic [31:0] EXP_UNM_RDATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] EXP_UNM_RESP  = 32'd0;
  localparam logic [31:0] EXP_UNM_RDATA = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] ctrl_o;
  logic [31:0] status_i = '0;

  int tests = 0;
  int fails = 0;

  dataplane_axil_regs #(.ADDR_WIDTH(32), .ID_VALUE(ID_VALUE)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ctrl_o(ctrl_o), .status_i(status_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_no_timeout", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    logic ar_hs;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      ar_hs = arvalid && arready;
      @(negedge clk);
      if (ar_hs) arvalid = 1'b0;
      n++;
    end
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_no_timeout", {31'd0, rvalid}, 32'd1);
    d = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0; arvalid = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_resps", {28'd0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ctrl", ctrl_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_readies", {29'd0, awready, wready, arready}, 32'd7);

    // SCRATCH at the top word
    axi_write(32'hFFFF_FFFF, 32'hAAAA_AAAA, 4'hF, resp);
    chk("scratch_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'hFFFF_FFFF, d, resp);
    chk("scratch_rdata", d, 32'hAAAA_AAAA);
    chk("scratch_rresp", {30'd0, resp}, 32'd0);
    axi_read(32'h0000_000C, d, resp);
    chk("wcount_1", d, 32'd1);

    // W ahead of AW, partial strobes over 0xFFFFFFFF
    axi_write(32'h0000_0004, 32'hFFFF_FFFF, 4'hF, resp);
    chk("ctrl_full", ctrl_o, 32'hFFFF_FFFF);
    @(negedge clk);
    wdata = 32'h1234_5678; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    chk("w_first_wready_low", {31'd0, wready}, 32'd0);
    wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    awaddr = 32'h0000_0004; awvalid = 1'b1;
    @(negedge clk);
    chk("aw_edge_bvalid_low", {31'd0, bvalid}, 32'd0);
    chk("aw_edge_ctrl_old", ctrl_o, 32'hFFFF_FFFF);
    awvalid = 1'b0;
    @(negedge clk);
    chk("commit_ctrl", ctrl_o, 32'hFF34_FF78);
    chk("commit_bvalid", {31'd0, bvalid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
      chk("bp_bresp", {30'd0, bresp}, 32'd0);
      chk("bp_aw_w_ready", {30'd0, awready, wready}, 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("b_done", {31'd0, bvalid}, 32'd0);
    chk("b_done_readies", {30'd0, awready, wready}, 32'd3);
    bready = 1'b0;

    // Read back-pressure on WCOUNT (3 accepted RW writes so far)
    @(negedge clk);
    araddr = 32'h0000_000C; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_bp_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rd_bp_rdata", rdata, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_bp_hold", {rdata[29:0], rresp}, {30'd3, 2'b00});
      chk("rd_bp_rvalid_arready", {30'd0, rvalid, arready}, 32'd2);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("r_done", {30'd0, rvalid, arready}, 32'd1);
    rready = 1'b0;

    // STATUS and ID
    status_i = 32'h5A5A_0F0F;
    axi_read(32'h0000_0008, d, resp);
    chk("status_rdata", d, 32'h5A5A_0F0F);
    axi_write(32'h0000_0000, 32'h0BAD_F00D, 4'hF, resp);
    chk("id_wr_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'h0000_0000, d, resp);
    chk("id_rdata", d, ID_VALUE);

    // Unmapped
    axi_write(32'h0000_0020, 32'h1111_2222, 4'hF, resp);
    chk("unm_bresp", {30'd0, resp}, EXP_UNM_RESP);
    axi_read(32'h0000_0020, d, resp);
    chk("unm_rresp", {30'd0, resp}, EXP_UNM_RESP);
    chk("unm_rdata", d, EXP_UNM_RDATA);
    axi_read(32'h0000_000C, d, resp);
    chk("wcount_unchanged", d, 32'd3);
    chk("ctrl_unchanged", ctrl_o, 32'hFF34_FF78);

    // Reset with a write response pending
    @(negedge clk);
    awaddr = 32'h0000_0004; wdata = 32'h1111_1111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    chk("pre_rst_ctrl", ctrl_o, 32'h1111_1111);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("async_rst_ctrl", ctrl_o, 32'd0);
    chk("async_rst_awready", {31'd0, awready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rerel_readies", {29'd0, awready, wready, arready}, 32'd7);
    axi_write(32'h0000_0004, 32'h0000_ABCD, 4'b0011, resp);
    chk("post_rst_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'h0000_0004, d, resp);
    chk("post_rst_ctrl", d, 32'h0000_ABCD);
    axi_read(32'h0000_000C, d, resp);
    chk("post_rst_wcount", d, 32'd1);
    axi_read(32'hFFFF_FFFC, d, resp);
    chk("post_rst_scratch", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
